// File: rtl/shift_seq.sv
// Multi-cycle shift engine: loads a word, then shifts it one bit per clock in SLL/SRL/SRA/ROL mode.
// Define SHIFT_SEQ_ROTATE_EN to build the rotate path for mode 11; otherwise mode 11 runs as SLL.
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       mode_q;

    // Returns {bit leaving the word, next word} for one shift step.
    function automatic logic [WIDTH:0] shift_step(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic si);
        logic signed [WIDTH-1:0] sd;
        logic [WIDTH:0]          r;
        sd = signed'(d);
        r  = {d[WIDTH-1], d[WIDTH-2:0], si};
        case (m)
            2'b01: r = {d[0], si, d[WIDTH-1:1]};
            2'b10: r = {d[0], sd >>> 1};
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11: r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
`endif
            default: ;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (amount != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt_q == AMT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            ser_out  <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
        end else if (clr) begin
            data_out <= '0;
            ser_out  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_out <= data_in;
                        cnt_q    <= amount;
                        mode_q   <= mode;
                    end
                end
                SHIFT: begin
                    {ser_out, data_out} <= shift_step(mode_q, data_out, ser_in);
                    cnt_q               <= cnt_q - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: expected serial bits and results are queued at command issue.
module tb_shift_seq;
    logic       clk = 1'b0;
    logic       rst, clr, start, ser_in;
    logic [1:0] mode;
    logic [3:0] amount;
    logic [7:0] data_in;
    logic       ready, busy, done, ser_out;
    logic [7:0] data_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] res_q[$];
    logic       ser_q[$];
    bit   mon_en = 1'b0;
    logic prev_busy = 1'b0;

    shift_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .mode(mode),
        .amount(amount), .ser_in(ser_in), .data_in(data_in),
        .ready(ready), .busy(busy), .done(done),
        .data_out(data_out), .ser_out(ser_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: queues each bit leaving the word and returns the final word.
    task automatic predict(input logic [1:0] m, input logic [3:0] amt, input logic [7:0] d,
                           input logic si, output logic [7:0] r);
        logic [7:0] w;
        logic [1:0] em;
        w  = d;
        em = m;
`ifndef SHIFT_SEQ_ROTATE_EN
        if (em == 2'b11) em = 2'b00;
`endif
        for (int i = 0; i < int'(amt); i++) begin
            case (em)
                2'b00: begin ser_q.push_back(w[7]); w = w << 1; w[0] = si; end
                2'b01: begin ser_q.push_back(w[0]); w = w >> 1; w[7] = si; end
                2'b10: begin ser_q.push_back(w[0]); w = {w[7], w[7:1]}; end
                default: begin ser_q.push_back(w[7]); w = {w[6:0], w[7]}; end
            endcase
        end
        r = w;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_busy) begin
                if (ser_q.size() == 0) check("ser_underflow", 1, 0);
                else check("ser_out", ser_out, ser_q.pop_front());
            end
            if (done) begin
                if (res_q.size() == 0) check("unexpected_done", 1, 0);
                else check("result", data_out, res_q.pop_front());
            end
        end
        prev_busy = busy;
    end

    task automatic run_cmd(input logic [1:0] m, input logic [3:0] amt, input logic [7:0] din,
                           input logic si, input logic [7:0] exp, input bit use_exp,
                           input int poke_at);
        logic [7:0] r;
        int k;
        predict(m, amt, din, si, r);
        res_q.push_back(use_exp ? exp : r);
        @(negedge clk);
        mode = m; amount = amt; data_in = din; ser_in = si; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load", data_out, din);
        check("busy_load", busy, (amt != 0));
        check("ready_low", ready, 0);
        k = 0;
        while (!done && k < 40) begin
            if (k == poke_at) begin
                start = 1'b1; data_in = ~din; mode = ~m;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 0, 1);
        check("latency", k, amt);
        @(negedge clk);
        check("done_width", done, 0);
        check("ready_back", ready, 1);
    endtask

    initial begin
        logic [7:0] r;
        rst = 1'b1; clr = 1'b0; start = 1'b0; mode = 2'b00;
        amount = 4'd0; ser_in = 1'b0; data_in = 8'h00;
        #12;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        check("rst_ser", ser_out, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("idle_ready", ready, 1);
        mon_en = 1'b1;

        run_cmd(2'b00, 4'd3, 8'hA5, 1'b0, 8'h28, 1'b1, -1);
        run_cmd(2'b10, 4'd2, 8'h90, 1'b0, 8'hE4, 1'b1, -1);
        run_cmd(2'b01, 4'd4, 8'h00, 1'b1, 8'hF0, 1'b1, -1);
`ifdef SHIFT_SEQ_ROTATE_EN
        run_cmd(2'b11, 4'd9, 8'h81, 1'b0, 8'h03, 1'b1, -1);
`else
        run_cmd(2'b11, 4'd9, 8'h81, 1'b0, 8'h00, 1'b1, -1);
`endif
        run_cmd(2'b00, 4'd0, 8'h5A, 1'b0, 8'h5A, 1'b1, -1);
        // start pulsed mid-shift must be ignored
        run_cmd(2'b00, 4'd5, 8'h3C, 1'b1, 8'h00, 1'b0, 2);

        // clr together with start in IDLE
        @(negedge clk);
        start = 1'b1; clr = 1'b1; data_in = 8'h77; amount = 4'd3; mode = 2'b00;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        check("clr_data", data_out, 0);
        check("clr_ready", ready, 1);
        check("clr_busy", busy, 0);
        @(negedge clk);
        check("clr_still_idle", ready, 1);

        // asynchronous reset mid-shift
        mon_en = 1'b0;
        @(negedge clk);
        mode = 2'b00; amount = 4'd7; data_in = 8'hF0; ser_in = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        check("busy_pre_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("arst_ready", ready, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_data", data_out, 0);
        check("arst_ser", ser_out, 0);
        repeat (2) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
        end
        rst = 1'b0;
        ser_q.delete();
        res_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        run_cmd(2'b01, 4'd6, 8'hC3, 1'b0, 8'h00, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom), 8'h00, 1'b0, -1);
        end

        @(negedge clk);
        check("res_q_empty", res_q.size(), 0);
        check("ser_q_empty", ser_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
